rf_write_arbiter: RTL
=====================

# rf_write_arbiter

Round-robin arbiter that shares the single write port of `register_file` between `NUM_REQ` writeback requesters, e.g. the ALU writeback and the load/multiply-divide unit. Each requester uses a valid/ready handshake. The arbiter grants one requester per cycle and registers the winning write into an output stage that drives `write_enable`, `address_3` and `write_data` of the register file one cycle later. Writes to x0 are accepted and discarded. The block also keeps a saturating count of contention cycles for performance analysis.

## Interface
Parameters:
- `WIDTH`, 32, data width; matches the register file.
- `ADD_WIDTH`, 5, register address width.
- `NUM_REQ`, 2, number of requesters; legal range 2..4.
- `CNT_WIDTH`, 16, width of the contention counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hold`  in  1  when 1, no grant is issued this cycle.
- `req_valid`  in  NUM_REQ  bit i is the write request from requester i.
- `req_addr`  in  NUM_REQ*ADD_WIDTH  destination register; requester i uses slice [i*ADD_WIDTH +: ADD_WIDTH].
- `req_data`  in  NUM_REQ*WIDTH  write data; requester i uses slice [i*WIDTH +: WIDTH].
- `req_ready`  out  NUM_REQ  one-hot or zero; combinational grant.
- `rf_write_enable`  out  1  registered; connects to `register_file.write_enable`.
- `rf_address`  out  ADD_WIDTH  registered; connects to `address_3`.
- `rf_write_data`  out  WIDTH  registered; connects to `write_data`.
- `grant_id`  out  clog2(NUM_REQ)  registered; index of the last accepted requester.
- `conflict_count`  out  CNT_WIDTH  registered; saturating contention counter.

## Operation
- **Transfer rule:** a transfer from requester i occurs when `req_valid[i]` and `req_ready[i]` are both 1 in the same cycle.
- **Requester obligation:** once `req_valid[i]` is asserted, it stays asserted with `req_addr` and `req_data` stable until the transfer. The bench checks this; the arbiter does not tolerate violations.
- **Arbitration:**
  - Search starts at `rr_ptr` and proceeds upward modulo `NUM_REQ`.
  - The first valid requester found is granted.
  - `req_ready` is all-zero when `reset=1`, when `hold=1`, or when no request is valid.
- **Pointer update:**
  - On a transfer from requester i: `rr_ptr` becomes (i+1) mod `NUM_REQ` and `grant_id` becomes i.
  - With no transfer, both are unchanged.
- **Output stage, on each clock edge:**
  - If a transfer occurred and its address is nonzero: `rf_write_enable`=1, `rf_address`=address, `rf_write_data`=data.
  - Otherwise `rf_write_enable`=0, and `rf_address` and `rf_write_data` hold their previous values.
- **x0 write:** the request is accepted (ready=1) and `rr_ptr`/`grant_id` advance, but no register-file write is produced.
- **Contention counter:** `conflict_count` increments by 1 in every cycle where two or more `req_valid` bits are 1 and `hold`=0. It saturates at all-ones and never wraps.
- **Reset values:** `rf_write_enable`=0, `rf_address`=0, `rf_write_data`=0, `grant_id`=0, `conflict_count`=0, `rr_ptr`=0.

## Timing
- Grant is combinational in the request cycle, so back-to-back transfers are possible every cycle with no bubble.
- Write latency: a transfer in cycle N produces `rf_write_enable`=1 in cycle N+1. The register file commits the data at the end of N+1, and its combinational bypass serves readers during N+1.
- Throughput: at most one write per cycle in total. A requester that is continuously valid waits at most `NUM_REQ`-1 cycles for a grant.
- `hold` acts in the same cycle it is asserted. An output-stage write already captured in the previous cycle still appears, because `hold` does not cancel it.
- Reset mid-operation:
  - A request presented while `reset`=1 is not accepted.
  - The cycle after reset deasserts shows `rf_write_enable`=0, even if a transfer would have occurred in the reset cycle.
- Simultaneous valid requests combined with `hold`=1: no grant is issued and the counter does not increment.

## Test plan
1. **Reset values:** reset for 2 cycles with all `req_valid`=1 -> `req_ready`=0, every registered output 0, and the first post-reset cycle has `rf_write_enable`=0.
2. **Single requester:** requester 0 writes addr 5, data 0xDEADBEEF in cycle N -> `req_ready[0]`=1 in N; `rf_write_enable`=1, `rf_address`=5, `rf_write_data`=0xDEADBEEF in N+1; `grant_id`=0.
3. **Round-robin fairness:** `NUM_REQ`=2, both requesters continuously valid for 6 cycles from reset -> grants alternate 0,1,0,1,0,1 and `conflict_count`=6.
4. **x0 write:** requester 1 writes addr 0, data 0x1234 -> `req_ready[1]`=1 and `rr_ptr` advances to 0, but `rf_write_enable`=0 in the next cycle.
5. **Hold:** `hold`=1 for 3 cycles while requester 0 is valid -> `req_ready`=0 throughout, counter unchanged. After `hold` drops, grant in that same cycle and the write appears one cycle later.
6. **Counter saturation:** `CNT_WIDTH`=4, 20 contention cycles -> `conflict_count` stops at 15 and does not wrap to 0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter sharing the register-file write port
// between NUM_REQ valid/ready writeback requesters. The grant is combinational.
// The winning write is registered into a one-cycle output stage. Writes to x0
// are accepted but dropped. A saturating counter tracks contention cycles.
module rf_write_arbiter #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 5,
  parameter int NUM_REQ   = 2,
  parameter int CNT_WIDTH = 16,
  localparam int GID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hold,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADD_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rf_write_enable,
  output logic [ADD_WIDTH-1:0]         rf_address,
  output logic [WIDTH-1:0]             rf_write_data,
  output logic [GID_W-1:0]             grant_id,
  output logic [CNT_WIDTH-1:0]         conflict_count
);

  // Per-requester views of the flattened address/data buses
  logic [ADD_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [WIDTH-1:0]     data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADD_WIDTH +: ADD_WIDTH];
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [GID_W-1:0]     rr_ptr_reg;
  logic [GID_W-1:0]     grant_id_reg;
  logic                 we_reg;
  logic [ADD_WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0]     data_reg;
  logic [CNT_WIDTH-1:0] conflict_reg;

  logic [NUM_REQ-1:0]   grant;
  logic [GID_W-1:0]     win_idx;
  logic [GID_W-1:0]     cand_idx;
  logic [GID_W-1:0]     ptr_next;
  logic                 found;
  logic                 transfer;
  logic                 contention;
  int                   cand;

  // Rotating priority search: first valid requester at or above rr_ptr
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(rr_ptr_reg) + k) % NUM_REQ;
      cand_idx = GID_W'(cand);
      if (!found && req_valid[cand_idx]) begin
        found           = 1'b1;
        win_idx         = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

  // Ready is suppressed during reset and hold; pointer wraps modulo NUM_REQ
  always_comb begin
    req_ready  = (reset || hold) ? '0 : grant;
    transfer   = |req_ready;
    ptr_next   = (win_idx == GID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    contention = ($countones(req_valid) >= 2) && !hold;
  end

  // Pointer, last-grant index and write output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg   <= '0;
      grant_id_reg <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
    end else begin
      we_reg <= 1'b0;
      if (transfer) begin
        rr_ptr_reg   <= ptr_next;
        grant_id_reg <= win_idx;
        // x0 writes consume the grant but never reach the register file
        if (addr_arr[win_idx] != '0) begin
          we_reg   <= 1'b1;
          addr_reg <= addr_arr[win_idx];
          data_reg <= data_arr[win_idx];
        end
      end
    end
  end

  // Saturating contention counter
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_reg <= '0;
    end else if (contention && (conflict_reg != '1)) begin
      conflict_reg <= conflict_reg + 1'b1;
    end
  end

  assign rf_write_enable = we_reg;
  assign rf_address      = addr_reg;
  assign rf_write_data   = data_reg;
  assign grant_id        = grant_id_reg;
  assign conflict_count  = conflict_reg;

endmodule
